// File: rtl/flash_fetch_pkg.sv
// Shared types and constants for the NOR-flash instruction fetch controller.
// The hit buffer in flash_fetch_ctrl is enabled by defining FETCH_HIT_BUF_EN.
package flash_fetch_pkg;

    localparam int FLASH_AW    = 19;
    localparam int INSTR_W     = 32;
    localparam int ADDR_W      = 32;
    localparam int ADDR_HI_BIT = 19;

    typedef enum logic [2:0] {
        FRST,
        IDLE,
        ACCESS,
        CAPTURE,
        RESP,
        RECOV
    } state_e;

    // Misaligned, or beyond the 1 MiB covered by the two 16-bit ROMs.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] != 2'b00) || (addr[ADDR_W-1:ADDR_HI_BIT+1] != '0);
    endfunction

endpackage

// File: rtl/flash_wait_cnt.sv
// Loadable down-counter with a done flag; times flash reset, access and bus recovery.
module flash_wait_cnt #(
    parameter int W       = 8,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/flash_fetch_ctrl.sv
// Fetch-side read controller for two 16-bit parallel NOR ROMs forming 32-bit instructions.
// Define FETCH_HIT_BUF_EN to add a one-entry last-fetch buffer that bypasses the flash.
module flash_fetch_ctrl
    import flash_fetch_pkg::*;
#(
    parameter int WAIT_CYC  = 7,
    parameter int RST_CYC   = 50,
    parameter int RECOV_CYC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [INSTR_W-1:0]  rsp_instr,
    output logic                rsp_err,
    output logic                flash_ce_n,
    output logic                flash_oe_n,
    output logic                flash_we_n,
    output logic                flash_reset_n,
    output logic                flash_byte_n,
    output logic [FLASH_AW-1:0] flash_a,
    input  logic [15:0]         flash_dq_lo,
    input  logic [15:0]         flash_dq_hi
);

    localparam int CNT_MAX = (RST_CYC > WAIT_CYC) ?
                             ((RST_CYC > RECOV_CYC) ? RST_CYC : RECOV_CYC) :
                             ((WAIT_CYC > RECOV_CYC) ? WAIT_CYC : RECOV_CYC);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] RECOV_LD = CNT_W'(RECOV_CYC - 1);

    state_e                state_q, state_d;
    logic [FLASH_AW-1:0]   flash_a_q, flash_a_d;
    logic                  strobe_n_q, strobe_n_d;
    logic                  flash_reset_n_q, flash_reset_n_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [INSTR_W-1:0]    rsp_instr_q, rsp_instr_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  cnt_load;
    logic [CNT_W-1:0]      cnt_ld_val;
    logic                  cnt_dec;
    logic                  cnt_done;

    logic                  hit;
    logic [INSTR_W-1:0]    hit_instr;

    flash_wait_cnt #(
        .W       (CNT_W),
        .RST_VAL (RST_CYC - 1)
    ) u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

`ifdef FETCH_HIT_BUF_EN
    logic                  tag_vld_q, tag_vld_d;
    logic [FLASH_AW-2:0]   tag_q, tag_d;
    logic [INSTR_W-1:0]    buf_q, buf_d;

    // Only successful flash reads fill the buffer; error responses never reach CAPTURE.
    always_comb begin
        tag_vld_d = tag_vld_q;
        tag_d     = tag_q;
        buf_d     = buf_q;
        if (state_q == CAPTURE) begin
            tag_vld_d = 1'b1;
            tag_d     = flash_a_q[FLASH_AW-1:1];
            buf_d     = {flash_dq_hi, flash_dq_lo};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld_q <= 1'b0;
            tag_q     <= '0;
            buf_q     <= '0;
        end else begin
            tag_vld_q <= tag_vld_d;
            tag_q     <= tag_d;
            buf_q     <= buf_d;
        end
    end

    assign hit       = tag_vld_q && (tag_q == req_addr[ADDR_HI_BIT:2]);
    assign hit_instr = buf_q;
`else
    assign hit       = 1'b0;
    assign hit_instr = '0;
`endif

    always_comb begin
        state_d         = state_q;
        flash_a_d       = flash_a_q;
        flash_reset_n_d = flash_reset_n_q;
        rsp_instr_d     = rsp_instr_q;
        rsp_err_d       = rsp_err_q;
        cnt_load        = 1'b0;
        cnt_ld_val      = WAIT_LD;
        cnt_dec         = 1'b0;

        case (state_q)
            FRST: begin
                if (cnt_done) begin
                    state_d         = IDLE;
                    flash_reset_n_d = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    if (addr_bad(req_addr)) begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b1;
                        rsp_instr_d = '0;
                    end else if (hit) begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b0;
                        rsp_instr_d = hit_instr;
                    end else begin
                        state_d    = ACCESS;
                        rsp_err_d  = 1'b0;
                        flash_a_d  = {req_addr[ADDR_HI_BIT:2], 1'b0};
                        cnt_load   = 1'b1;
                        cnt_ld_val = WAIT_LD;
                    end
                end
            end
            ACCESS: begin
                if (cnt_done) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            CAPTURE: begin
                rsp_instr_d = {flash_dq_hi, flash_dq_lo};
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d    = RECOV;
                    cnt_load   = 1'b1;
                    cnt_ld_val = RECOV_LD;
                end
            end
            RECOV: begin
                if (cnt_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = FRST;
            end
        endcase

        // Strobes follow the next state so they change on the same edge as the FSM.
        strobe_n_d  = !((state_d == ACCESS) || (state_d == CAPTURE));
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= FRST;
            flash_a_q       <= '0;
            strobe_n_q      <= 1'b1;
            flash_reset_n_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_instr_q     <= '0;
            rsp_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            flash_a_q       <= flash_a_d;
            strobe_n_q      <= strobe_n_d;
            flash_reset_n_q <= flash_reset_n_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_instr_q     <= rsp_instr_d;
            rsp_err_q       <= rsp_err_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_instr     = rsp_instr_q;
    assign rsp_err       = rsp_err_q;
    assign flash_ce_n    = strobe_n_q;
    assign flash_oe_n    = strobe_n_q;
    assign flash_we_n    = 1'b1;
    assign flash_byte_n  = 1'b1;
    assign flash_reset_n = flash_reset_n_q;
    assign flash_a       = flash_a_q;

endmodule

// File: tb/tb_flash_fetch_ctrl.sv
// Self-checking bench for flash_fetch_ctrl: directed fetches, stalls, mid-access reset
// and randomized traffic against a simple ROM/response model (hit buffer per FETCH_HIT_BUF_EN).
module tb_flash_fetch_ctrl;

    localparam int WAIT_CYC  = 7;
    localparam int RST_CYC   = 50;
    localparam int RECOV_CYC = 1;
`ifdef FETCH_HIT_BUF_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        flash_ce_n;
    logic        flash_oe_n;
    logic        flash_we_n;
    logic        flash_reset_n;
    logic        flash_byte_n;
    logic [18:0] flash_a;
    logic [15:0] flash_dq_lo;
    logic [15:0] flash_dq_hi;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Model of the last successful fetch, used to predict buffer hits.
    bit          tag_vld;
    logic [31:0] tag_addr;

    always #5 clk = ~clk;

    flash_fetch_ctrl #(
        .WAIT_CYC  (WAIT_CYC),
        .RST_CYC   (RST_CYC),
        .RECOV_CYC (RECOV_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_instr     (rsp_instr),
        .rsp_err       (rsp_err),
        .flash_ce_n    (flash_ce_n),
        .flash_oe_n    (flash_oe_n),
        .flash_we_n    (flash_we_n),
        .flash_reset_n (flash_reset_n),
        .flash_byte_n  (flash_byte_n),
        .flash_a       (flash_a),
        .flash_dq_lo   (flash_dq_lo),
        .flash_dq_hi   (flash_dq_hi)
    );

    function automatic logic [15:0] rom_lo(input logic [17:0] w);
        if (w == 18'd4) return 16'h0093;
        return 16'(32'(w) * 7 + 32'h01c3);
    endfunction

    function automatic logic [15:0] rom_hi(input logic [17:0] w);
        if (w == 18'd4) return 16'h0010;
        return 16'(32'(w) ^ 32'h0000_beef);
    endfunction

    // ROMs drive valid data only while selected; junk otherwise exposes mistimed captures.
    assign flash_dq_lo = (!flash_ce_n && !flash_oe_n) ? rom_lo(flash_a[18:1]) : 16'hdead;
    assign flash_dq_hi = (!flash_ce_n && !flash_oe_n) ? rom_hi(flash_a[18:1]) : 16'hdead;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic release_reset();
        int n;
        bit rr_early;
        rst_n    = 1'b1;
        n        = 0;
        rr_early = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (!flash_reset_n && req_ready) rr_early = 1'b1;
        end while (!flash_reset_n && n < 200);
        check("rst_len", n, RST_CYC);
        check("ready_early", rr_early, 0);
        check("ready_after_rst", req_ready, 1);
        tag_vld = 1'b0;
        $display("reset released: flash_reset_n low %0d cycles", n);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int stall);
        logic        exp_err;
        logic        exp_hit;
        logic [17:0] w;
        logic [31:0] exp_instr;
        int          exp_lat;
        int          lat;
        int          ce_low;
        int          wait_c;
        bit          a_ok;

        exp_err   = (addr[1:0] != 2'b00) || (addr[31:20] != 12'h0);
        exp_hit   = HIT_EN && !exp_err && tag_vld && (tag_addr == addr);
        w         = addr[19:2];
        exp_instr = exp_err ? 32'h0 : {rom_hi(w), rom_lo(w)};
        exp_lat   = (exp_err || exp_hit) ? 1 : WAIT_CYC + 2;

        req_valid = 1'b1;
        req_addr  = addr;
        rsp_ready = 1'b0;
        wait_c    = 0;
        while (!req_ready && wait_c < 200) begin
            @(negedge clk);
            wait_c++;
        end
        check("accept", req_ready, 1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end

        lat    = 0;
        ce_low = 0;
        a_ok   = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) req_valid = 1'b0;
            if (!flash_ce_n || !flash_oe_n) begin
                ce_low++;
                if (flash_a !== {addr[19:2], 1'b0} || flash_ce_n !== flash_oe_n) a_ok = 1'b0;
            end
        end while (!rsp_valid && lat < 100);

        check("latency", lat, exp_lat);
        check("ce_low_cycles", ce_low, (exp_lat == 1) ? 0 : WAIT_CYC + 1);
        check("flash_addr", a_ok, 1);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_instr", rsp_instr, exp_instr);

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_ctl", {rsp_valid, req_ready, flash_ce_n, flash_oe_n}, 4'b1011);
            check("stall_instr", rsp_instr, exp_instr);
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
        check("recov_ctl", {flash_ce_n, flash_oe_n, req_ready}, 3'b110);
        repeat (RECOV_CYC) @(negedge clk);
        check("idle_again", req_ready, 1);

        if (!exp_err) begin
            tag_vld  = 1'b1;
            tag_addr = addr;
        end
        $display("fetch addr=%08h instr=%08h err=%0d lat=%0d ce_low=%0d stall=%0d",
                 addr, rsp_instr, exp_err, lat, ce_low, stall);
    endtask

    initial begin
        logic [31:0] pool [6];
        logic [31:0] a;
        int          r;
        bit          seen_rsp;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        rsp_ready = 1'b0;
        tag_vld   = 1'b0;
        tag_addr  = 32'h0;
        repeat (3) @(negedge clk);

        check("rst_flash_reset_n", flash_reset_n, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_instr", rsp_instr, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_strobes", {flash_ce_n, flash_oe_n, flash_we_n, flash_byte_n}, 4'hf);
        check("rst_flash_a", flash_a, 0);

        // Request held throughout reset release must not be taken before IDLE.
        req_valid = 1'b1;
        req_addr  = 32'h0000_0010;
        release_reset();

        do_fetch(32'h0000_0010, 0);
        do_fetch(32'h0000_0006, 0);
        do_fetch(32'h0000_0040, 20);
        do_fetch(32'h0010_0000, 2);
        do_fetch(32'h0000_0020, 0);
        do_fetch(32'h0000_0020, 0);

        // Reset asserted in the third ACCESS cycle aborts the fetch.
        req_valid = 1'b1;
        req_addr  = 32'h0000_0080;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_strobes", {flash_ce_n, flash_oe_n}, 2'b11);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_flash_reset_n", flash_reset_n, 0);
        check("abort_req_ready", req_ready, 0);
        @(negedge clk);
        seen_rsp = 1'b0;
        fork
            release_reset();
            begin
                for (int i = 0; i < RST_CYC + 5; i++) begin
                    @(negedge clk);
                    if (rsp_valid) seen_rsp = 1'b1;
                end
            end
        join
        check("abort_no_rsp", seen_rsp, 0);
        do_fetch(32'h0000_0020, 0);

        for (int i = 0; i < 6; i++) pool[i] = {12'h0, 18'($urandom), 2'b00};
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            a = pool[$urandom_range(0, 5)];
            if (r == 0) a = a | 32'($urandom_range(1, 3));
            else if (r == 1) a = a | (32'($urandom_range(1, 4095)) << 20);
            do_fetch(a, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
